// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush sequencing: init bubbles, load-use, branch, mul/div occupancy
// Optional HAZARD_PERF_EN adds StallCount/FlushCount performance counters.
module hazard_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MD_LATENCY     = 4,
    parameter int INIT_BUBBLES   = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_ADDR_WIDTH-1:0] rs1D,
    input  logic [REG_ADDR_WIDTH-1:0] rs2D,
    input  logic [REG_ADDR_WIDTH-1:0] rdE,
    input  logic                      RegWriteE,
    input  logic                      LoadE,
    input  logic                      PCSrcE,
    input  logic                      MdStartE,
    output logic                      StallF,
    output logic                      StallD,
    output logic                      StallE,
    output logic                      FlushD,
    output logic                      FlushE,
    output logic                      MdBusy,
    output logic                      MdDoneE
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]               StallCount,
    output logic [31:0]               FlushCount
`endif
);

    localparam int CNT_MAX = (MD_LATENCY > INIT_BUBBLES) ? MD_LATENCY : INIT_BUBBLES;
    localparam int CW      = $clog2(CNT_MAX) + 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(INIT_BUBBLES - 1);
    localparam logic [CW-1:0] CNT_MD   = CW'(MD_LATENCY - 2);

    typedef enum logic [1:0] {INIT, RUN, MD_BUSY} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          lu;
    logic          md;

    assign lu = LoadE & RegWriteE & (rdE != '0) & ((rdE == rs1D) | (rdE == rs2D));
    assign md = MdStartE & ~PCSrcE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
            cnt   <= CNT_INIT;
        end else begin
            case (state)
                INIT: begin
                    if (cnt == '0) state <= RUN;
                    else           cnt   <= cnt - CW'(1);
                end
                RUN: begin
                    if (md) begin
                        state <= MD_BUSY;
                        cnt   <= CNT_MD;
                    end
                end
                MD_BUSY: begin
                    if (cnt == '0) state <= RUN;
                    else           cnt   <= cnt - CW'(1);
                end
                default: begin
                    state <= INIT;
                    cnt   <= CNT_INIT;
                end
            endcase
        end
    end

    // Outputs must react in the same cycle as the Execute-stage inputs, so they are decoded combinationally.
    always_comb begin
        StallF  = 1'b0;
        StallD  = 1'b0;
        StallE  = 1'b0;
        FlushD  = 1'b0;
        FlushE  = 1'b0;
        MdBusy  = 1'b0;
        MdDoneE = 1'b0;
        case (state)
            RUN: begin
                if (PCSrcE) begin
                    FlushD = 1'b1;
                    FlushE = 1'b1;
                end else if (md) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    StallE = 1'b1;
                    MdBusy = 1'b1;
                end else if (lu) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    FlushE = 1'b1;
                end
            end
            MD_BUSY: begin
                MdBusy = 1'b1;
                if (cnt == '0) begin
                    MdDoneE = 1'b1;
                end else begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    StallE = 1'b1;
                end
            end
            default: begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end
        endcase
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else if (state != INIT) begin
            if (StallD) StallCount <= StallCount + 32'd1;
            if (FlushD) FlushCount <= FlushCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - randomized self-checking bench for hazard_ctrl against a cycle-offset reference model
module tb_hazard_ctrl;

    localparam int AW = 5;
    localparam int L  = 4;
    localparam int IB = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] rs1D = '0, rs2D = '0, rdE = '0;
    logic          RegWriteE = 1'b0, LoadE = 1'b0, PCSrcE = 1'b0, MdStartE = 1'b0;
    logic          StallF, StallD, StallE, FlushD, FlushE, MdBusy, MdDoneE;
`ifdef HAZARD_PERF_EN
    logic [31:0]   StallCount, FlushCount;
`endif

    hazard_ctrl #(.REG_ADDR_WIDTH(AW), .MD_LATENCY(L), .INIT_BUBBLES(IB)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1D(rs1D), .rs2D(rs2D), .rdE(rdE),
        .RegWriteE(RegWriteE), .LoadE(LoadE), .PCSrcE(PCSrcE), .MdStartE(MdStartE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .MdBusy(MdBusy), .MdDoneE(MdDoneE)
`ifdef HAZARD_PERF_EN
        , .StallCount(StallCount), .FlushCount(FlushCount)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          md_t = -1000;
    logic [31:0] stall_m = '0;
    logic [31:0] flush_m = '0;
    logic [6:0]  obs;
    logic [6:0]  exp_v;
    int          done_seen;

    assign obs = {StallF, StallD, StallE, FlushD, FlushE, MdBusy, MdDoneE};

    function automatic logic in_md_window();
        return (md_t >= 0) && (cyc > md_t) && (cyc <= md_t + L - 1);
    endfunction

    // Reference: {StallF,StallD,StallE,FlushD,FlushE,MdBusy,MdDoneE}, from cycles since reset release
    function automatic logic [6:0] exp_out();
        logic lu;
        if (!rst_n || cyc < IB) return 7'b0001100;
        if (in_md_window()) return (cyc == md_t + L - 1) ? 7'b0000011 : 7'b1110010;
        lu = LoadE && RegWriteE && (rdE != 0) && (rdE == rs1D || rdE == rs2D);
        if (PCSrcE)   return 7'b0001100;
        if (MdStartE) return 7'b1110010;
        if (lu)       return 7'b1100100;
        return 7'b0000000;
    endfunction

    task automatic drive(input logic ld, input logic rw, input logic pc, input logic ms,
                         input logic [AW-1:0] rd, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        LoadE = ld; RegWriteE = rw; PCSrcE = pc; MdStartE = ms;
        rdE = rd; rs1D = r1; rs2D = r2;
        #1;
    endtask

    task automatic drive_random();
        logic ms;
        ms = ($urandom_range(0, 9) == 0);
        drive(ms ? 1'b0 : 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) == 0), ms,
              AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)));
    endtask

    task automatic advance();
        logic [6:0] e;
        e = exp_out();
        if (rst_n && cyc >= IB) begin
            if (e[5]) stall_m = stall_m + 32'd1;
            if (e[3]) flush_m = flush_m + 32'd1;
            if (!in_md_window() && MdStartE && !PCSrcE) md_t = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
        md_t = -1000;
        stall_m = '0;
        flush_m = '0;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 5'd3, 5'd3);
        checks++;
        if (obs !== 7'b0001100) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=%b", obs, 7'b0001100);
        end
`ifdef HAZARD_PERF_EN
        checks++;
        if (StallCount !== 32'd0 || FlushCount !== 32'd0) begin
            failures++;
            $display("FAIL reset_counters got=%0d/%0d want=0/0", StallCount, FlushCount);
        end
`endif
        release_reset();
        for (int i = 0; i < IB + 2; i++) begin
            if (i < IB) drive_random();
            else        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
            exp_v = exp_out();
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL init_seq cyc=%0d got=%b want=%b", cyc, obs, exp_v);
            end
            advance();
        end
    endtask

    task automatic test_load_use();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 5'd1, 5'd5);
                1: drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd5);
                2: drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
                default: drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 5'd7, 5'd2);
            endcase
            exp_v = exp_out();
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL load_use step=%0d got=%b want=%b", i, obs, exp_v);
            end
            advance();
        end
    endtask

    task automatic test_branch_priority();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 5'd5, 5'd5, 5'd5);
        checks++;
        if (obs !== 7'b0001100) begin
            failures++;
            $display("FAIL branch_over_lu got=%b want=%b", obs, 7'b0001100);
        end
        advance();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0);
        checks++;
        if (obs !== 7'b0001100) begin
            failures++;
            $display("FAIL branch_over_md got=%b want=%b", obs, 7'b0001100);
        end
        advance();
    endtask

    task automatic test_muldiv();
        logic [6:0] want [L+1];
        for (int i = 0; i < L - 1; i++) want[i] = 7'b1110010;
        want[L-1] = 7'b0000011;
        want[L]   = 7'b0000000;
        for (int i = 0; i <= L; i++) begin
            if (i == 0)      drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0);
            else if (i == 1) drive(1'b1, 1'b1, 1'b1, 1'b1, 5'd4, 5'd4, 5'd4);
            else             drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
            exp_v = exp_out();
            checks++;
            if (obs !== want[i] || obs !== exp_v) begin
                failures++;
                $display("FAIL muldiv t+%0d got=%b want=%b", i, obs, want[i]);
            end
            advance();
        end
    endtask

    task automatic test_reset_mid_md();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0);
        advance();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        checks++;
        if (obs !== 7'b1110010) begin
            failures++;
            $display("FAIL md_busy_before_reset got=%b want=%b", obs, 7'b1110010);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 7'b0001100) begin
            failures++;
            $display("FAIL async_reset got=%b want=%b", obs, 7'b0001100);
        end
        done_seen = 0;
        for (int i = 0; i < L + 1; i++) begin
            @(posedge clk);
            #2;
            if (MdDoneE !== 1'b0) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            failures++;
            $display("FAIL md_abandoned done_cycles=%0d want=0", done_seen);
        end
`ifdef HAZARD_PERF_EN
        checks++;
        if (StallCount !== 32'd0 || FlushCount !== 32'd0) begin
            failures++;
            $display("FAIL counters_after_reset got=%0d/%0d want=0/0", StallCount, FlushCount);
        end
`endif
        release_reset();
        for (int i = 0; i < IB; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
            advance();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive_random();
            exp_v = exp_out();
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL random cyc=%0d got=%b want=%b", cyc, obs, exp_v);
            end
            advance();
`ifdef HAZARD_PERF_EN
            checks++;
            if (StallCount !== stall_m || FlushCount !== flush_m) begin
                failures++;
                $display("FAIL perf_counters got=%0d/%0d want=%0d/%0d", StallCount, FlushCount, stall_m, flush_m);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_priority();
        test_muldiv();
        test_reset_mid_md();
        test_muldiv();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
